// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - request/stage constants, default mask tables and FSM state type
package hazard_pkg;

  localparam int HZ_COMPRESS   = 0;
  localparam int HZ_LOAD_USE   = 1;
  localparam int HZ_MULDIV     = 2;
  localparam int HZ_JUMP       = 3;
  localparam int HZ_TRAP_CSR   = 4;
  localparam int HZ_TRAP_ECALL = 5;
  localparam int HZ_RAM_IF     = 6;
  localparam int HZ_RAM_MEM    = 7;

  localparam int STG_PC     = 0;
  localparam int STG_IF     = 1;
  localparam int STG_IF_ID  = 2;
  localparam int STG_ID_EX  = 3;
  localparam int STG_EX_MEM = 4;
  localparam int STG_MEM_WB = 5;

  // Request 7 occupies the top slice, request 0 the bottom slice.
  localparam logic [47:0] HZ_STALL_DEFAULT = {
    6'b011111, 6'b000011, 6'b000010, 6'b111111,
    6'b000010, 6'b000111, 6'b000111, 6'b000010
  };

  localparam logic [47:0] HZ_FLUSH_DEFAULT = {
    6'b100000, 6'b000000, 6'b001110, 6'b001110,
    6'b001110, 6'b010000, 6'b001000, 6'b000010
  };

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_t;

endpackage

// File: rtl/hz_prio_enc.sv
// rtl/hz_prio_enc.sv - highest-set-bit priority encoder with valid flag
module hz_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Ascending scan: the last set bit seen is the highest index.
    for (int i = 0; i < N; i++) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/pipe_hazard_arbiter.sv
// rtl/pipe_hazard_arbiter.sv - stall/flush arbiter with reset flush, watchdog and event counters
module pipe_hazard_arbiter
  import hazard_pkg::*;
#(
  parameter int                       NSTAGE        = 6,
  parameter int                       NREQ          = 8,
  parameter logic [NREQ*NSTAGE-1:0]   STALL_MASKS   = HZ_STALL_DEFAULT,
  parameter logic [NREQ*NSTAGE-1:0]   FLUSH_MASKS   = HZ_FLUSH_DEFAULT,
  parameter bit                       MERGE         = 1'b0,
  parameter int                       RST_FLUSH_CYC = 2,
  parameter int                       WDOG_LIMIT    = 1024,
  parameter int                       CNT_W         = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] cnt_sel_i,
  input  logic                    cnt_clr_i,
  output logic [NSTAGE-1:0]       stall_o,
  output logic [NSTAGE-1:0]       flush_o,
  output logic                    cause_valid_o,
  output logic [$clog2(NREQ)-1:0] cause_id_o,
  output logic [CNT_W-1:0]        cnt_o,
  output logic                    wdog_o
);

  localparam int SEQ_W = (RST_FLUSH_CYC > 1) ? $clog2(RST_FLUSH_CYC) : 1;
  localparam int WD_W  = (WDOG_LIMIT > 1) ? $clog2(WDOG_LIMIT) : 1;

  arb_state_t        state_q, state_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              hit;
  logic [$clog2(NREQ)-1:0] win;
  logic              run;
  logic [NSTAGE-1:0] sel_stall, sel_flush, m_stall, m_flush;
  logic [CNT_W-1:0]  cnt_q [NREQ];
  logic [WD_W-1:0]   wd_q;

  hz_prio_enc #(.N(NREQ)) u_enc (
    .req   (req_i),
    .valid (hit),
    .idx   (win)
  );

  always_comb begin
    sel_stall = STALL_MASKS[int'(win)*NSTAGE +: NSTAGE];
    sel_flush = FLUSH_MASKS[int'(win)*NSTAGE +: NSTAGE];
    m_stall   = '0;
    m_flush   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_i[i]) begin
        m_stall |= STALL_MASKS[i*NSTAGE +: NSTAGE];
        m_flush |= FLUSH_MASKS[i*NSTAGE +: NSTAGE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FLUSH;
      seq_q   <= SEQ_W'(RST_FLUSH_CYC - 1);
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    seq_d         = seq_q;
    stall_o       = '0;
    flush_o       = '0;
    cause_valid_o = 1'b0;
    cause_id_o    = '0;
    run           = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        flush_o = '1;
        if (seq_q == '0) state_d = ST_RUN;
        else             seq_d   = seq_q - SEQ_W'(1);
      end
      ST_RUN: begin
        run           = 1'b1;
        cause_valid_o = hit;
        cause_id_o    = win;
        if (hit) begin
          if (MERGE) begin
            // A held stage must keep its contents, so stall masks out flush.
            stall_o = m_stall;
            flush_o = m_flush & ~m_stall;
          end else begin
            stall_o = sel_stall;
            flush_o = sel_flush;
          end
        end
      end
      default: state_d = ST_FLUSH;
    endcase
    if (rst) begin
      stall_o       = '0;
      flush_o       = '1;
      cause_valid_o = 1'b0;
      cause_id_o    = '0;
      run           = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr_i) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (run && hit && (cnt_q[win] != '1)) begin
      cnt_q[win] <= cnt_q[win] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_o <= '0;
    else     cnt_o <= (int'(cnt_sel_i) < NREQ) ? cnt_q[cnt_sel_i] : '0;
  end

  // Count saturates at WDOG_LIMIT-1; the flag latches on the following stalled edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q   <= '0;
      wdog_o <= 1'b0;
    end else if (run && stall_o[0]) begin
      if (wd_q == WD_W'(WDOG_LIMIT - 1)) wdog_o <= 1'b1;
      else                               wd_q   <= wd_q + WD_W'(1);
    end else begin
      wd_q <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_arbiter.sv
// tb/tb_pipe_hazard_arbiter.sv - directed self-checking bench for pipe_hazard_arbiter
module tb_pipe_hazard_arbiter;
  import hazard_pkg::*;

  localparam logic [47:0] S_FULL = HZ_STALL_DEFAULT;
  localparam logic [47:0] F_FULL = HZ_FLUSH_DEFAULT;
  localparam logic [35:0] S6 = S_FULL[35:0];
  localparam logic [35:0] F6 = F_FULL[35:0];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // u0: default parameters
  logic [7:0]  req0 = '0;
  logic [2:0]  sel0 = '0;
  logic        clr0 = 1'b0;
  logic [5:0]  stall0, flush0;
  logic        cv0, wd0;
  logic [2:0]  id0;
  logic [31:0] cnt0;

  // u1: merged, narrow counters, short watchdog
  logic [7:0]  req1 = '0;
  logic [2:0]  sel1 = '0;
  logic        clr1 = 1'b0;
  logic [5:0]  stall1, flush1;
  logic        cv1, wd1;
  logic [2:0]  id1;
  logic [3:0]  cnt1;

  // u2: six requests
  logic [5:0]  req2 = '0;
  logic [2:0]  sel2 = '0;
  logic        clr2 = 1'b0;
  logic [5:0]  stall2, flush2;
  logic        cv2, wd2;
  logic [2:0]  id2;
  logic [31:0] cnt2;

  pipe_hazard_arbiter u0 (
    .clk(clk), .rst(rst), .req_i(req0), .cnt_sel_i(sel0), .cnt_clr_i(clr0),
    .stall_o(stall0), .flush_o(flush0), .cause_valid_o(cv0), .cause_id_o(id0),
    .cnt_o(cnt0), .wdog_o(wd0)
  );

  pipe_hazard_arbiter #(.MERGE(1'b1), .CNT_W(4), .WDOG_LIMIT(8)) u1 (
    .clk(clk), .rst(rst), .req_i(req1), .cnt_sel_i(sel1), .cnt_clr_i(clr1),
    .stall_o(stall1), .flush_o(flush1), .cause_valid_o(cv1), .cause_id_o(id1),
    .cnt_o(cnt1), .wdog_o(wd1)
  );

  pipe_hazard_arbiter #(.NREQ(6), .STALL_MASKS(S6), .FLUSH_MASKS(F6)) u2 (
    .clk(clk), .rst(rst), .req_i(req2), .cnt_sel_i(sel2), .cnt_clr_i(clr2),
    .stall_o(stall2), .flush_o(flush2), .cause_valid_o(cv2), .cause_id_o(id2),
    .cnt_o(cnt2), .wdog_o(wd2)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    req0 = 8'h80;
    tick(3);
    n_cmp++; if (stall0 !== 6'b000000) begin n_fail++; $display("FAIL rst_stall got %b exp 000000", stall0); end
    n_cmp++; if (flush0 !== 6'b111111) begin n_fail++; $display("FAIL rst_flush got %b exp 111111", flush0); end
    n_cmp++; if (cv0 !== 1'b0 || id0 !== 3'd0) begin n_fail++; $display("FAIL rst_cause got %b/%0d exp 0/0", cv0, id0); end
    n_cmp++; if (cnt0 !== 32'd0 || wd0 !== 1'b0) begin n_fail++; $display("FAIL rst_regs got %0d/%b exp 0/0", cnt0, wd0); end
    rst = 1'b0;
    #1;
    n_cmp++; if (flush0 !== 6'b111111 || stall0 !== 6'b0) begin n_fail++; $display("FAIL flush_cyc1 got %b/%b exp 111111/000000", flush0, stall0); end
    tick(1);
    n_cmp++; if (flush0 !== 6'b111111 || stall0 !== 6'b0) begin n_fail++; $display("FAIL flush_cyc2 got %b/%b exp 111111/000000", flush0, stall0); end
    tick(1);
    n_cmp++; if (stall0 !== 6'b011111) begin n_fail++; $display("FAIL run_stall got %b exp 011111", stall0); end
    n_cmp++; if (flush0 !== 6'b100000) begin n_fail++; $display("FAIL run_flush got %b exp 100000", flush0); end
    n_cmp++; if (id0 !== 3'd7 || cv0 !== 1'b1) begin n_fail++; $display("FAIL run_cause got %b/%0d exp 1/7", cv0, id0); end
  endtask

  task automatic test_priority;
    req0 = 8'b0000_1010;
    #1;
    n_cmp++; if (stall0 !== 6'b000010 || flush0 !== 6'b001110) begin n_fail++; $display("FAIL prio_hi got %b/%b exp 000010/001110", stall0, flush0); end
    n_cmp++; if (id0 !== 3'd3) begin n_fail++; $display("FAIL prio_hi_id got %0d exp 3", id0); end
    req0 = 8'b0000_0010;
    #1;
    n_cmp++; if (stall0 !== 6'b000111 || flush0 !== 6'b001000) begin n_fail++; $display("FAIL prio_lo got %b/%b exp 000111/001000", stall0, flush0); end
    n_cmp++; if (id0 !== 3'd1) begin n_fail++; $display("FAIL prio_lo_id got %0d exp 1", id0); end
  endtask

  task automatic test_empty;
    req0 = 8'h00;
    #1;
    n_cmp++; if (stall0 !== 6'b0 || flush0 !== 6'b0 || cv0 !== 1'b0) begin n_fail++; $display("FAIL empty got %b/%b/%b exp 0/0/0", stall0, flush0, cv0); end
  endtask

  task automatic test_counters;
    req0 = 8'h00;
    clr0 = 1'b1;
    tick(1);
    clr0 = 1'b0;
    req0 = 8'h02;
    tick(5);
    req0 = 8'h00;
    sel0 = 3'd1;
    tick(1);
    n_cmp++; if (cnt0 !== 32'd5) begin n_fail++; $display("FAIL cnt_five got %0d exp 5", cnt0); end
    req0 = 8'h02;
    clr0 = 1'b1;
    tick(1);
    n_cmp++; if (cnt0 !== 32'd5) begin n_fail++; $display("FAIL cnt_preclr got %0d exp 5", cnt0); end
    clr0 = 1'b0;
    req0 = 8'h00;
    tick(1);
    n_cmp++; if (cnt0 !== 32'd0) begin n_fail++; $display("FAIL cnt_clr got %0d exp 0", cnt0); end
  endtask

  task automatic test_merge;
    req1 = 8'b0000_0110;
    #1;
    n_cmp++; if (stall1 !== 6'b000111 || flush1 !== 6'b011000) begin n_fail++; $display("FAIL merge_a got %b/%b exp 000111/011000", stall1, flush1); end
    n_cmp++; if (id1 !== 3'd2 || cv1 !== 1'b1) begin n_fail++; $display("FAIL merge_a_id got %b/%0d exp 1/2", cv1, id1); end
    req1 = 8'b0000_1010;
    #1;
    n_cmp++; if (stall1 !== 6'b000111 || flush1 !== 6'b001000) begin n_fail++; $display("FAIL merge_b got %b/%b exp 000111/001000", stall1, flush1); end
    n_cmp++; if (id1 !== 3'd3) begin n_fail++; $display("FAIL merge_b_id got %0d exp 3", id1); end
    req1 = 8'h00;
    tick(1);
  endtask

  task automatic test_watchdog;
    req1 = 8'h02;
    tick(7);
    req1 = 8'h00;
    tick(1);
    n_cmp++; if (wd1 !== 1'b0) begin n_fail++; $display("FAIL wdog_seven got %b exp 0", wd1); end
    req1 = 8'h02;
    tick(9);
    n_cmp++; if (wd1 !== 1'b1) begin n_fail++; $display("FAIL wdog_nine got %b exp 1", wd1); end
    req1 = 8'h00;
    tick(3);
    n_cmp++; if (wd1 !== 1'b1) begin n_fail++; $display("FAIL wdog_sticky got %b exp 1", wd1); end
    rst = 1'b1;
    tick(1);
    n_cmp++; if (wd1 !== 1'b0) begin n_fail++; $display("FAIL wdog_rst got %b exp 0", wd1); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_saturate;
    req1 = 8'h02;
    tick(20);
    req1 = 8'h00;
    sel1 = 3'd1;
    tick(1);
    n_cmp++; if (cnt1 !== 4'd15) begin n_fail++; $display("FAIL cnt_sat got %0d exp 15", cnt1); end
  endtask

  task automatic test_out_of_range;
    req2 = 6'h02;
    tick(3);
    req2 = 6'h00;
    sel2 = 3'd1;
    tick(1);
    n_cmp++; if (cnt2 !== 32'd3) begin n_fail++; $display("FAIL oor_inrange got %0d exp 3", cnt2); end
    sel2 = 3'd7;
    tick(1);
    n_cmp++; if (cnt2 !== 32'd0) begin n_fail++; $display("FAIL oor_sel7 got %0d exp 0", cnt2); end
    sel2 = 3'd6;
    tick(1);
    n_cmp++; if (cnt2 !== 32'd0) begin n_fail++; $display("FAIL oor_sel6 got %0d exp 0", cnt2); end
  endtask

  initial begin
    test_reset;
    test_priority;
    test_empty;
    test_counters;
    test_merge;
    test_watchdog;
    test_saturate;
    test_out_of_range;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
